// File: rtl/mem_access_stage.sv
// MEM stage: load/store over a ready-based data-memory handshake, with lane sizing,
// load extension, timeout abort and MEM/WB register. Optional counters: MEM_PERF_CNT_EN.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWriteM,
    input  logic             ResultSrcM,
    input  logic             MemWriteM,
    input  logic [31:0]      ALUResultM,
    input  logic [31:0]      WriteDataM,
    input  logic [4:0]       RdM,
    input  logic [2:0]       funct3M,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ready,
    input  logic [31:0]      dmem_rdata,
    output logic             stall_m,
    output logic             RegWriteW,
    output logic             ResultSrcW,
    output logic [31:0]      ALUResultW,
    output logic [31:0]      ReadDataW,
    output logic [4:0]       RdW,
    output logic             misaligned_w,
    output logic             bus_err_w,
    output logic [CNT_W-1:0] perf_acc,
    output logic [CNT_W-1:0] perf_stall,
    output logic             fsm_state_o
);
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam int          TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          req_c, stall_c, complete, timeout;

    logic mem_op, is_b, is_h, is_w, misaligned;
    assign mem_op     = ResultSrcM | MemWriteM;
    assign is_b       = (funct3M[1:0] == 2'b00);
    assign is_h       = (funct3M[1:0] == 2'b01);
    assign is_w       = ~is_b & ~is_h;
    assign misaligned = (is_h & ALUResultM[0]) | (is_w & (ALUResultM[1:0] != 2'b00));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_c    = 1'b0;
        stall_c  = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !misaligned) begin
                    req_c = 1'b1;
                    if (dmem_ready) begin
                        complete = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_WAIT;
                        cnt_d   = TW'(1);
                    end
                end
            end
            S_WAIT: begin
                req_c = 1'b1;
                // Ready takes priority over the timeout in the same cycle.
                if (dmem_ready) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == TLAST) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dmem_req    = req_c & rst_n;
    assign stall_m     = stall_c & rst_n;
    assign dmem_we     = MemWriteM & dmem_req;
    assign dmem_addr   = {ALUResultM[31:2], 2'b00};
    assign fsm_state_o = (state_q == S_WAIT);

    always_comb begin
        dmem_wdata = WriteDataM;
        dmem_be    = 4'b1111;
        if (MemWriteM) begin
            if (is_b) begin
                dmem_wdata = {4{WriteDataM[7:0]}};
                dmem_be    = 4'b0001 << ALUResultM[1:0];
            end else if (is_h) begin
                dmem_wdata = {2{WriteDataM[15:0]}};
                dmem_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    always_comb begin
        case (ALUResultM[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (is_b)      ld_ext = {{24{~funct3M[2] & ld_byte[7]}}, ld_byte};
        else if (is_h) ld_ext = {{16{~funct3M[2] & ld_half[15]}}, ld_half};
        else           ld_ext = dmem_rdata;
    end

    // Anything other than a plain ALU op or a completed access becomes a bubble.
    logic w_pass, mis_d;
    assign w_pass = ((state_q == S_IDLE) & ~mem_op) | complete;
    assign mis_d  = (state_q == S_IDLE) & mem_op & misaligned;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            RegWriteW    <= 1'b0;
            ResultSrcW   <= 1'b0;
            ALUResultW   <= '0;
            ReadDataW    <= '0;
            RdW          <= '0;
            misaligned_w <= 1'b0;
            bus_err_w    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            RegWriteW    <= w_pass & RegWriteM;
            ResultSrcW   <= w_pass & ResultSrcM;
            ALUResultW   <= ALUResultM;
            ReadDataW    <= (complete & ResultSrcM) ? ld_ext : 32'h0;
            RdW          <= RdM;
            misaligned_w <= mis_d;
            bus_err_w    <= timeout;
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [CNT_W-1:0] acc_q, stl_q;
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            stl_q <= '0;
        end else begin
            acc_q <= acc_q + CNT_W'(complete);
            stl_q <= stl_q + CNT_W'(stall_c);
        end
    end
    assign perf_acc   = acc_q;
    assign perf_stall = stl_q;
`else
    assign perf_acc   = '0;
    assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change and outputs are sampled
// 1-2 time units after the falling (active) edge.
module tb_mem_access_stage;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             RegWriteM = 1'b0, ResultSrcM = 1'b0, MemWriteM = 1'b0;
    logic [31:0]      ALUResultM = '0, WriteDataM = '0;
    logic [4:0]       RdM = '0;
    logic [2:0]       funct3M = '0;
    logic             dmem_req, dmem_we;
    logic [31:0]      dmem_addr, dmem_wdata;
    logic [3:0]       dmem_be;
    logic             dmem_ready = 1'b0;
    logic [31:0]      dmem_rdata = '0;
    logic             stall_m, RegWriteW, ResultSrcW;
    logic [31:0]      ALUResultW, ReadDataW;
    logic [4:0]       RdW;
    logic             misaligned_w, bus_err_w;
    logic [CNT_W-1:0] perf_acc, perf_stall;
    logic             fsm_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    logic [31:0] ld_addr [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [2:0]  ld_f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .funct3M(funct3M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall_m(stall_m), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
        .misaligned_w(misaligned_w), .bus_err_w(bus_err_w),
        .perf_acc(perf_acc), .perf_stall(perf_stall), .fsm_state_o(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_m(input logic rw, input logic rs, input logic mw,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd, input logic [2:0] f3);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        ALUResultM = addr;
        WriteDataM = wd;
        RdM        = rd;
        funct3M    = f3;
    endtask

    task automatic drive_nop();
        drive_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'b000);
        dmem_ready = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_alu();
        drive_m(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 3'b000);
        dmem_ready = 1'b0;
        #1;
        check("alu_req", dmem_req, 0);
        check("alu_stall", stall_m, 0);
        tick();
        check("alu_regw", RegWriteW, 1);
        check("alu_rsrc", ResultSrcW, 0);
        check("alu_res", ALUResultW, 32'h1234);
        check("alu_rd", RdW, 5);
        check("alu_rdata", ReadDataW, 0);
    endtask

    task automatic run_sh_wait();
        int stalls = 0;
        drive_m(1'b0, 1'b0, 1'b1, 32'h202, 32'hDEADBEEF, 5'd0, 3'b001);
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            #1;
            check("sh_req", dmem_req, 1);
            check("sh_we", dmem_we, 1);
            check("sh_be", dmem_be, 4'b1100);
            check("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
            check("sh_addr", dmem_addr, 32'h200);
            if (stall_m) stalls++;
            tick();
            check("sh_bubble", RegWriteW, 0);
            if (i == 0) check("sh_in_wait", fsm_state, 1);
        end
        check("sh_stalls", stalls, 3);
        check("sh_idle", fsm_state, 0);
        dmem_ready = 1'b0;
    endtask

    task automatic run_lw_timeout(input int ready_at);
        int stalls = 0;
        int cycles = 0;
        logic err = 1'b0;
        logic done = 1'b0;
        drive_m(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd7, 3'b010);
        dmem_rdata = 32'h12345678;
        for (int i = 0; i < 20 && !done; i++) begin
            dmem_ready = (i == ready_at);
            #1;
            if (stall_m) stalls++;
            tick();
            cycles++;
            if (bus_err_w) begin
                err  = 1'b1;
                done = 1'b1;
            end else if (RegWriteW) begin
                done = 1'b1;
            end
        end
        check("to_stalls", stalls, 15);
        check("to_cycles", cycles, 16);
        check("to_bus_err", err, (ready_at < 0) ? 1 : 0);
        check("to_idle", fsm_state, 0);
        if (ready_at >= 0) check("to_rdata", ReadDataW, 32'h12345678);
        drive_nop();
        #1;
        tick();
        check("to_err_clear", bus_err_w, 0);
    endtask

    initial begin
        #12;
        check("rst_req", dmem_req, 0);
        check("rst_regw", RegWriteW, 0);
        check("rst_rdata", ReadDataW, 0);
        check("rst_state", fsm_state, 0);
        rst_n = 1'b1;

        run_alu();

        // Loads with same-cycle ready: byte/half lane selection and extension.
        exp_q.push_back(32'hFFFFFF80);
        exp_q.push_back(32'h00000080);
        exp_q.push_back(32'hFFFF80FF);
        exp_q.push_back(32'h0000FF00);
        exp_q.push_back(32'h80FFFF00);
        dmem_rdata = 32'h80FFFF00;
        for (int i = 0; i < 5; i++) begin
            drive_m(1'b1, 1'b1, 1'b0, ld_addr[i], 32'h0, 5'(10 + i), ld_f3[i]);
            dmem_ready = 1'b1;
            #1;
            check("ld_req", dmem_req, 1);
            check("ld_we", dmem_we, 0);
            check("ld_be", dmem_be, 4'b1111);
            check("ld_stall", stall_m, 0);
            tick();
            check("ld_data", ReadDataW, exp_q.pop_front());
            check("ld_rsrc", ResultSrcW, 1);
            check("ld_rd", RdW, 10 + i);
        end

        // SB and SW lane placement with immediate ready.
        drive_m(1'b0, 1'b0, 1'b1, 32'h001, 32'h123456EF, 5'd0, 3'b000);
        dmem_ready = 1'b1;
        #1;
        check("sb_be", dmem_be, 4'b0010);
        check("sb_wdata", dmem_wdata, 32'hEFEFEFEF);
        tick();
        drive_m(1'b0, 1'b0, 1'b1, 32'h204, 32'hDEADBEEF, 5'd0, 3'b010);
        #1;
        check("sw_be", dmem_be, 4'b1111);
        check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        check("sw_stall", stall_m, 0);
        tick();

        run_sh_wait();

        drive_m(1'b1, 1'b1, 1'b0, 32'h301, 32'h0, 5'd9, 3'b010);
        dmem_ready = 1'b0;
        #1;
        check("mis_req", dmem_req, 0);
        check("mis_stall", stall_m, 0);
        tick();
        check("mis_flag", misaligned_w, 1);
        check("mis_regw", RegWriteW, 0);
        check("mis_rsrc", ResultSrcW, 0);
        drive_nop();
        #1;
        tick();
        check("mis_clear", misaligned_w, 0);

        run_lw_timeout(-1);
        run_lw_timeout(15);

        // Asynchronous reset in the second WAIT cycle.
        drive_m(1'b0, 1'b0, 1'b1, 32'h202, 32'hDEADBEEF, 5'd3, 3'b001);
        dmem_ready = 1'b0;
        #1;
        tick();
        tick();
        check("ar_pre_req", dmem_req, 1);
        check("ar_pre_state", fsm_state, 1);
        check("ar_pre_alu", ALUResultW, 32'h202);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_req", dmem_req, 0);
        check("ar_stall", stall_m, 0);
        check("ar_state", fsm_state, 0);
        check("ar_alu", ALUResultW, 0);
        check("ar_rd", RdW, 0);
        check("ar_regw", RegWriteW, 0);
        drive_nop();
        #1;
        rst_n = 1'b1;
        tick();
        run_sh_wait();
        run_alu();
`ifdef MEM_PERF_CNT_EN
        check("perf_acc", perf_acc, 1);
        check("perf_stall", perf_stall, 3);
`else
        check("perf_acc_tied", perf_acc, 0);
        check("perf_stall_tied", perf_stall, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the WB stage. It takes the EX/MEM outputs, runs load/store accesses over a ready-based data-memory handshake, and sizes, aligns and extends the data. It stalls the pipeline while memory is busy and holds the MEM/WB register state.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before the access is aborted with a bus error (>=2)
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  pipeline clock; all state updates on the falling edge, matching the pipeline registers
rst_n  in  1  asynchronous active-low reset
RegWriteM  in  1  register-write enable from EX/MEM
ResultSrcM  in  1  1 = load instruction
MemWriteM  in  1  1 = store instruction
ALUResultM  in  32  effective address, or ALU result
WriteDataM  in  32  store data (rs2)
RdM  in  5  destination register
funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
dmem_req  out  1  access request (combinational)
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address {ALUResultM[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ready  in  1  access complete this cycle; rdata valid for loads
dmem_rdata  in  32  raw read word
stall_m  out  1  hold PC/IF/ID/EX and EX/MEM (combinational)
RegWriteW  out  1  MEM/WB register-write enable
ResultSrcW  out  1  MEM/WB result select
ALUResultW  out  32  MEM/WB ALU result
ReadDataW  out  32  MEM/WB extended load data
RdW  out  5  MEM/WB destination
misaligned_w  out  1  one-cycle flag: misaligned access dropped
bus_err_w  out  1  one-cycle flag: access timed out
perf_acc  out  CNT_W  completed accesses (optional feature)
perf_stall  out  CNT_W  stall cycles (optional feature)

Behaviour:
- Reset (async): state IDLE, timeout counter 0, every registered output 0. dmem_req is gated by rst_n, so it drops immediately, including mid-WAIT.
- mem_op = ResultSrcM | MemWriteM.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. Any other funct3 value is treated as W.
- FSM states: IDLE, WAIT.
- IDLE, no mem_op: no request, stall_m=0. Next edge latches RegWriteM/ResultSrcM/ALUResultM/RdM into the W outputs; ReadDataW=0.
- IDLE, misaligned mem_op: dmem_req=0, stall_m=0. Next edge writes a bubble (RegWriteW=0, ResultSrcW=0) and misaligned_w=1 for one cycle.
- IDLE, aligned mem_op: dmem_req=1.
  - If dmem_ready: complete at the next edge, no stall.
  - Else stall_m=1 and the FSM goes to WAIT with counter=1; the W stage gets a bubble.
- WAIT: dmem_req=1 and inputs are held upstream by the stall. stall_m = ~dmem_ready & ~(counter==TIMEOUT-1).
  - dmem_ready: complete and return to IDLE.
  - Counter reaches TIMEOUT-1 without ready: bubble, bus_err_w=1 for one cycle, return to IDLE.
  - Otherwise the counter increments and a bubble is inserted.
  - Ready in the same cycle as timeout: ready wins.
- Completion: W outputs latch the M inputs. Loads set ReadDataW to the selected lane:
  - B/BU: byte at addr[1:0], sign- or zero-extended to 32.
  - H/HU: half at addr[1], sign- or zero-extended to 32.
  - W: full word.
  - Stores: ReadDataW=0.
- Store lanes:
  - SB: wdata={4{byte}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{half}}, be=4'b0011<<(2*addr[1]).
  - SW: be=4'b1111.
  - Loads: be=4'b1111, dmem_we=0.
- misaligned_w and bus_err_w clear on the next edge unless re-triggered.

Optional Feature:
MEM_PERF_CNT_EN.
- Defined: perf_acc increments on each completed access; perf_stall increments on each edge where stall_m=1. Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: no counter flops are built and both ports are tied to 0.

Test Plan:
1. ALU op: RegWriteM=1, ALUResultM=0x1234, RdM=5, no mem_op -> next edge RegWriteW=1, ALUResultW=0x1234, RdW=5, stall_m never 1.
2. LB at 0x103, dmem_rdata=0x80FF_FF00, ready same cycle -> ReadDataW=0xFFFF_FF80; LBU at the same address -> 0x0000_0080; LH at 0x102 -> 0xFFFF_80FF.
3. SH at 0x202, WriteDataM=0xDEAD_BEEF -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1; ready after 3 wait cycles -> stall_m high for exactly 3 cycles, 3 bubbles, then RegWriteW=0.
4. LW at 0x301 -> dmem_req=0, misaligned_w=1 for one cycle, RegWriteW=0, no stall.
5. LW with ready never asserted, TIMEOUT=16 -> stall_m high for exactly 15 cycles, then bus_err_w=1, FSM back in IDLE; repeat with ready in cycle 15 -> normal completion, no bus_err_w.
6. rst_n low in WAIT cycle 2 -> dmem_req drops immediately, all W outputs 0, next access starts from IDLE. With MEM_PERF_CNT_EN defined, run cases 3 and 1 -> perf_acc=1, perf_stall=3.
